flash_arbiter: RTL
==================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 The module SHALL have parameter LATENCY, default 11, meaning the number of cycles from the flash_ready pulse to valid flash_data_in.
REQ-002 The module SHALL have parameter ADDR_W, default 16, meaning the flash address width.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 req0  input  1  network-controller read request, level, held until done0.
REQ-006 addr0  input  ADDR_W  network-controller read address.
REQ-007 req1  input  1  SPI-loader request, level, held until done1.
REQ-008 we1  input  1  SPI-loader request type: 1 = write, 0 = read.
REQ-009 addr1  input  ADDR_W  SPI-loader address.
REQ-010 wdata1  input  16  SPI-loader write data.
REQ-011 flash_data_in  input  16  flash read data.
REQ-012 flash_ready  output  1  one-cycle flash access strobe.
REQ-013 flash_we  output  1  write qualifier, valid only with flash_ready.
REQ-014 flash_address  output  ADDR_W  latched access address.
REQ-015 flash_wdata  output  16  latched write data.
REQ-016 gnt0, gnt1  output  1 each  level, high from the ISSUE cycle through the COMPLETE cycle of the owning requester.
REQ-017 done0, done1  output  1 each  one-cycle completion pulse.
REQ-018 rdata  output  16  captured read data, stable from the done pulse until the next capture.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and COMPLETE.
REQ-021 IDLE: if any req is high, the FSM SHALL latch the winner, its address, we1 and wdata1, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022 Arbitration SHALL be round-robin with a single last-owner bit.
REQ-023 When both reqs are high, the arbiter SHALL grant the requester that did not own the previous access; after reset, requester 0 SHALL win.
REQ-024 A lone request SHALL be granted regardless of the last-owner bit.
REQ-025 ISSUE SHALL last one cycle with flash_ready=1, flash_we equal to the latched we, and flash_address/flash_wdata driving the latched values.
REQ-026 The next state after ISSUE SHALL be WAIT, with the wait counter cleared to 0.
REQ-027 WAIT: the counter SHALL increment each cycle, the FSM SHALL stay in WAIT for exactly LATENCY cycles, and it SHALL go to COMPLETE after the LATENCY-th cycle.
REQ-028 For reads, rdata SHALL capture flash_data_in on the edge ending the LATENCY-th WAIT cycle; for writes, rdata SHALL be unchanged.
REQ-029 COMPLETE SHALL last one cycle, assert done of the owner, and update the last-owner bit; the FSM SHALL then go to IDLE.
REQ-030 Request-to-done latency SHALL be LATENCY+2 cycles, counted from the IDLE cycle sampling req to the done cycle (13 cycles at default).
REQ-031 Back-to-back accesses SHALL be separated by exactly one IDLE cycle.
REQ-032 req changes while busy SHALL be ignored; the latched address and data SHALL NOT change mid-access.
REQ-033 A requester holding req high in the IDLE cycle after its done SHALL be treated as a new request.
REQ-034 flash_ready SHALL never be high in two consecutive cycles.
REQ-035 gnt0 and gnt1 SHALL never be high simultaneously.
REQ-036 The wait counter SHALL be wide enough for LATENCY without wrapping.

Reset
REQ-037 On n_rst low, regardless of the current state, the FSM SHALL go to IDLE, the last-owner bit SHALL be set to favour requester 0, and rdata, flash_address and flash_wdata SHALL be 0.
REQ-038 On n_rst low, flash_ready, flash_we, gnt0, gnt1, done0, done1 and busy SHALL all be 0.
REQ-039 A reset mid-access SHALL produce no done pulse, and no flash_ready SHALL be issued until a new request arrives after release.

Verification
REQ-040 Single read: req0=1, addr0=0x0005, flash_data_in=0xA3C7 on the 11th WAIT cycle -> flash_ready one cycle with address 0x0005, done0 13 cycles after req0 sampled, rdata=0xA3C7.
REQ-041 Contention: req0 and req1 asserted in the same cycle after reset -> requester 0 is served first, requester 1 ISSUE follows after done0 plus one IDLE cycle; a repeat of both requests then serves requester 1 first.
REQ-042 Write: req1=1, we1=1, addr1=0x0120, wdata1=0xBEEF -> flash_ready=1 and flash_we=1 for one cycle with 0x0120/0xBEEF, done1 at cycle 13, rdata unchanged.
REQ-043 Address change mid-access: addr0 changed during WAIT -> flash_address holds the original value and done0 timing is unchanged.
REQ-044 Reset during WAIT cycle 5 -> all outputs 0 immediately, no done pulse; after release with req0 still high, a fresh ISSUE occurs one cycle later.
REQ-045 Continuous req0 and req1 held for 100 cycles -> grants strictly alternate and flash_ready is never high in consecutive cycles.

Source files
------------

// File: rtl/flash_arbiter.sv
// Two-requester round-robin arbiter for a fixed-latency flash port.
// Requester 0 is the network controller (read only), requester 1 is the SPI loader.
module flash_arbiter #(
    parameter int unsigned LATENCY = 11,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata1,
    input  logic [15:0]       flash_data_in,
    output logic              flash_ready,
    output logic              flash_we,
    output logic [ADDR_W-1:0] flash_address,
    output logic [15:0]       flash_wdata,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [15:0]       rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_last, w_last_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [15:0]       r_wdata, w_wdata_nxt;
    logic [15:0]       r_rdata, w_rdata_nxt;
    logic              w_sel;

    logic r_flash_ready, r_flash_we, r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
    logic w_ready_nxt, w_fwe_nxt, w_gnt0_nxt, w_gnt1_nxt, w_done0_nxt, w_done1_nxt, w_busy_nxt;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, arbitration and capture logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_sel       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    // r_last == 1 means requester 1 owned the previous access
                    w_sel       = (req0 && req1) ? ~r_last : req1;
                    w_owner_nxt = w_sel;
                    w_addr_nxt  = w_sel ? addr1 : addr0;
                    w_we_nxt    = w_sel & we1;
                    if (w_sel) begin
                        w_wdata_nxt = wdata1;
                    end
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = COMPLETE;
                    if (!r_we) begin
                        w_rdata_nxt = flash_data_in;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            COMPLETE: begin
                w_last_nxt  = r_owner;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_busy_nxt  = (w_state_nxt != IDLE);
    assign w_ready_nxt = (w_state_nxt == ISSUE);
    assign w_fwe_nxt   = w_ready_nxt & w_we_nxt;
    assign w_gnt0_nxt  = w_busy_nxt & ~w_owner_nxt;
    assign w_gnt1_nxt  = w_busy_nxt & w_owner_nxt;
    assign w_done0_nxt = (w_state_nxt == COMPLETE) & ~w_owner_nxt;
    assign w_done1_nxt = (w_state_nxt == COMPLETE) & w_owner_nxt;

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_flash_ready <= 1'b0;
            r_flash_we    <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_owner       <= w_owner_nxt;
            r_last        <= w_last_nxt;
            r_we          <= w_we_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_rdata       <= w_rdata_nxt;
            r_flash_ready <= w_ready_nxt;
            r_flash_we    <= w_fwe_nxt;
            r_gnt0        <= w_gnt0_nxt;
            r_gnt1        <= w_gnt1_nxt;
            r_done0       <= w_done0_nxt;
            r_done1       <= w_done1_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign flash_ready   = r_flash_ready;
    assign flash_we      = r_flash_we;
    assign flash_address = r_addr;
    assign flash_wdata   = r_wdata;
    assign gnt0          = r_gnt0;
    assign gnt1          = r_gnt1;
    assign done0         = r_done0;
    assign done1         = r_done1;
    assign rdata         = r_rdata;
    assign busy          = r_busy;

endmodule
